lifo_access_arbiter: RTL and testbench

Shares a single LIFO instance between `Num_Requesters` clients. Each client issues push or pop requests with a valid/response handshake. The block arbitrates between clients, drives the LIFO's one-cycle `Write`/`Read` strobes, and returns pop data or a full/empty error to the winner. It sits directly in front of the LIFO data port; clients never touch the LIFO directly.

---
 rtl/lifo_arb_pkg.sv | 20 ++
 rtl/lifo_arb_picker.sv | 47 ++++
 rtl/lifo_access_arbiter.sv | 104 ++++++++++
 tb/tb_lifo_access_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// Shared types and helpers for the LIFO access arbiter: FSM state encoding,
// op encoding and the client-index width helper.
package lifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   // Width of a client index; a single client still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lifo_arb_picker.sv
// Combinational winner selection. LIFO_ARB_ROUND_ROBIN_EN selects round-robin
// starting at ptr; otherwise the lowest requesting index wins and ptr is ignored.
module lifo_arb_picker
   import lifo_arb_pkg::*;
#(
   parameter int unsigned Num_Requesters = 2,
   parameter int unsigned Idx_Width      = 1
) (
   input  logic [Num_Requesters-1:0] req,
   input  logic [Idx_Width-1:0]      ptr,
   output logic                      grant_valid,
   output logic [Idx_Width-1:0]      grant_idx
);

`ifdef LIFO_ARB_ROUND_ROBIN_EN
   always_comb begin
      int unsigned j;
      grant_valid = 1'b0;
      grant_idx   = '0;
      j           = 0;
      // Scan from ptr, wrapping once around the request vector.
      for (int unsigned k = 0; k < Num_Requesters; k++) begin
         j = 32'(ptr) + k;
         if (j >= Num_Requesters) j = j - Num_Requesters;
         if (!grant_valid && req[j]) begin
            grant_valid = 1'b1;
            grant_idx   = Idx_Width'(j);
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int unsigned k = 0; k < Num_Requesters; k++) begin
         if (!grant_valid && req[k]) begin
            grant_valid = 1'b1;
            grant_idx   = Idx_Width'(k);
         end
      end
   end
`endif

endmodule

// File: rtl/lifo_access_arbiter.sv
// Arbitrates push/pop requests from several clients onto one LIFO data port.
// Round-robin arbitration is enabled with LIFO_ARB_ROUND_ROBIN_EN.
module lifo_access_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int unsigned Num_Requesters = 2,
   parameter int unsigned Data_Width     = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [Num_Requesters-1:0]            req_valid,
   input  logic [Num_Requesters-1:0]            req_pop,
   input  logic [Num_Requesters*Data_Width-1:0] req_data,
   output logic [Num_Requesters-1:0]            rsp_valid,
   output logic                                 rsp_err,
   output logic [Data_Width-1:0]                rsp_data,
   output logic                                 busy,
   output logic                                 lifo_write,
   output logic                                 lifo_read,
   output logic [Data_Width-1:0]                lifo_data_in,
   input  logic [Data_Width-1:0]                lifo_data_out,
   input  logic                                 lifo_full,
   input  logic                                 lifo_empty
);

   localparam int unsigned IW = idx_width(Num_Requesters);

   state_t        state;
   logic [IW-1:0] win_q;
   logic [IW-1:0] ptr_q;
   logic          op_q;
   logic          err_q;

   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          pick_op;
   logic          pick_err;
   logic [IW-1:0] ptr_next;

   lifo_arb_picker #(
      .Num_Requesters (Num_Requesters),
      .Idx_Width      (IW)
   ) u_picker (
      .req         (req_valid),
      .ptr         (ptr_q),
      .grant_valid (pick_valid),
      .grant_idx   (pick_idx)
   );

   // Flags are stable in IDLE since no strobe is outstanding.
   assign pick_op  = req_pop[pick_idx];
   assign pick_err = (pick_op == OP_POP) ? lifo_empty : lifo_full;
   assign ptr_next = (pick_idx == IW'(Num_Requesters - 1)) ? '0 : pick_idx + IW'(1);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         win_q        <= '0;
         ptr_q        <= '0;
         op_q         <= OP_PUSH;
         err_q        <= 1'b0;
         rsp_valid    <= '0;
         rsp_err      <= 1'b0;
         rsp_data     <= '0;
         lifo_write   <= 1'b0;
         lifo_read    <= 1'b0;
         lifo_data_in <= '0;
      end else begin
         rsp_valid  <= '0;
         rsp_err    <= 1'b0;
         lifo_write <= 1'b0;
         lifo_read  <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  win_q <= pick_idx;
                  op_q  <= pick_op;
                  err_q <= pick_err;
                  ptr_q <= ptr_next;
                  if (!pick_err) lifo_data_in <= req_data[pick_idx*Data_Width +: Data_Width];
                  state <= pick_err ? RESP : ISSUE;
               end
            end
            ISSUE: begin
               lifo_write <= (op_q == OP_PUSH);
               lifo_read  <= (op_q == OP_POP);
               state      <= CAPTURE;
            end
            CAPTURE: begin
               if (op_q == OP_POP) rsp_data <= lifo_data_out;
               state <= RESP;
            end
            RESP: begin
               rsp_valid[win_q] <= 1'b1;
               rsp_err          <= err_q;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lifo_access_arbiter.sv
// Directed bench for lifo_access_arbiter with a depth-4 LIFO model and a
// response scoreboard; expectations follow LIFO_ARB_ROUND_ROBIN_EN.
module tb_lifo_access_arbiter;

   localparam int N = 2;
   localparam int W = 8;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_pop = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   rsp_valid;
   logic           rsp_err;
   logic [W-1:0]   rsp_data;
   logic           busy;
   logic           lifo_write;
   logic           lifo_read;
   logic [W-1:0]   lifo_data_in;
   logic [W-1:0]   lifo_data_out;
   logic           lifo_full;
   logic           lifo_empty;

   always #5 clk = ~clk;

   lifo_access_arbiter #(.Num_Requesters(N), .Data_Width(W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_pop(req_pop),
      .req_data(req_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .rsp_data(rsp_data), .busy(busy), .lifo_write(lifo_write),
      .lifo_read(lifo_read), .lifo_data_in(lifo_data_in),
      .lifo_data_out(lifo_data_out), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
   );

   // LIFO model: top of stack visible on Data_out, flags from stack pointer.
   logic [W-1:0] mem [DEPTH];
   int           sp;
   assign lifo_full     = (sp == DEPTH);
   assign lifo_empty    = (sp == 0);
   assign lifo_data_out = (sp > 0) ? mem[sp-1] : '0;
   always @(posedge clk) begin
      if (reset) sp <= 0;
      else if (lifo_write && !lifo_full) begin
         mem[sp] <= lifo_data_in;
         sp      <= sp + 1;
      end else if (lifo_read && !lifo_empty) sp <= sp - 1;
   end

   typedef struct {
      int           client;
      bit           pop;
      bit           err;
      logic [W-1:0] data;
      bit           chk_data;
      int           cyc;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_rsp = 0;
   int   wcount = 0;
   int   rcount = 0;
   bit   prev_strobe = 1'b0;
   bit   hold = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (lifo_write || lifo_read) begin
         check("strobe_excl", 32'(lifo_write & lifo_read), 0);
         check("strobe_b2b", 32'(prev_strobe), 0);
         if (lifo_write) wcount++;
         if (lifo_read) rcount++;
         if (sb.size() == 0) check("stray_strobe", 32'(sb.size()), 1);
         else begin
            check("strobe_op", 32'(lifo_read), 32'(sb[0].pop));
            check("strobe_on_err", 32'(sb[0].err), 0);
            if (!sb[0].pop) check("wr_data", 32'(lifo_data_in), 32'(sb[0].data));
         end
      end
      prev_strobe = lifo_write | lifo_read;
      if (rsp_valid != '0) begin
         if (sb.size() == 0) check("stray_rsp", 32'(rsp_valid), 0);
         else begin
            e = sb.pop_front();
            check("rsp_client", 32'(rsp_valid), 32'(1) << e.client);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            if (e.chk_data) check("rsp_data", 32'(rsp_data), 32'(e.data));
            if (e.lat != 0) check("rsp_lat", cyc - e.cyc, e.lat);
            n_rsp++;
            for (int i = 0; i < N; i++)
               if (rsp_valid[i] && !hold) req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic wait_rsp(input int n);
      int target;
      int budget;
      target = n_rsp + n;
      budget = 40 * n;
      while (n_rsp < target && budget > 0) begin
         step();
         budget--;
      end
      if (n_rsp < target) check("timeout", n_rsp, target);
   endtask

   // Raise a request and queue its expected response.
   task automatic request(input int c, input bit pop, input logic [W-1:0] d,
                          input bit err, input logic [W-1:0] exp_d,
                          input bit chk_d, input int lat);
      exp_t e;
      e.client = c; e.pop = pop; e.err = err; e.chk_data = chk_d;
      e.data = pop ? exp_d : d; e.cyc = cyc; e.lat = lat;
      sb.push_back(e);
      req_pop[c]        = pop;
      req_data[c*W +: W] = d;
      req_valid[c]      = 1'b1;
   endtask

   task automatic expect_only(input int c, input logic [W-1:0] d, input bit err);
      exp_t e;
      e.client = c; e.pop = 1'b0; e.err = err; e.chk_data = 1'b0;
      e.data = d; e.cyc = cyc; e.lat = 0;
      sb.push_back(e);
   endtask

   initial begin
      int w0;
      int r0;
      repeat (3) step();
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_strobes", 32'({lifo_write, lifo_read}), 0);
      check("rst_data_in", 32'(lifo_data_in), 0);
      reset = 1'b0;
      step();

      // Pop from empty LIFO: error after one cycle, no read strobe.
      r0 = rcount;
      request(0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 2);
      wait_rsp(1);
      check("empty_pop_no_read", rcount - r0, 0);

      // Push 10 then pop it back.
      w0 = wcount;
      request(0, 1'b0, 8'd10, 1'b0, 8'h00, 1'b0, 4);
      wait_rsp(1);
      check("push_one_write", wcount - w0, 1);
      request(0, 1'b1, 8'h00, 1'b0, 8'd10, 1'b1, 4);
      wait_rsp(1);

      // Fill with 1..4, fifth push errors, then drain in reverse order.
      for (int k = 1; k <= 4; k++) begin
         request(1, 1'b0, 8'(k), 1'b0, 8'h00, 1'b0, 4);
         wait_rsp(1);
      end
      w0 = wcount;
      request(1, 1'b0, 8'd5, 1'b1, 8'h00, 1'b0, 2);
      wait_rsp(1);
      check("full_push_no_write", wcount - w0, 0);
      for (int k = 4; k >= 1; k--) begin
         request(1, 1'b1, 8'h00, 1'b0, 8'(k), 1'b1, 4);
         wait_rsp(1);
      end

      // Simultaneous pushes: client 0 first, then client 1; pop yields 7.
      request(0, 1'b0, 8'd5, 1'b0, 8'h00, 1'b0, 0);
      request(1, 1'b0, 8'd7, 1'b0, 8'h00, 1'b0, 0);
      wait_rsp(2);
      request(0, 1'b1, 8'h00, 1'b0, 8'd7, 1'b1, 4);
      wait_rsp(1);
      request(0, 1'b1, 8'h00, 1'b0, 8'd5, 1'b1, 4);
      wait_rsp(1);

      // Reset during ISSUE of a push of 99: operation dropped silently.
      w0 = wcount;
      request(0, 1'b0, 8'd99, 1'b0, 8'h00, 1'b0, 0);
      step();
      check("busy_in_issue", 32'(busy), 1);
      reset = 1'b1;
      step();
      check("rst_mid_strobes", 32'({lifo_write, lifo_read}), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_rsp", 32'(rsp_valid), 0);
      sb.delete();
      req_valid = '0;
      reset = 1'b0;
      repeat (6) step();
      check("rst_mid_no_write", wcount - w0, 0);
      request(1, 1'b0, 8'd42, 1'b0, 8'h00, 1'b0, 4);
      wait_rsp(1);
      request(1, 1'b1, 8'h00, 1'b0, 8'd42, 1'b1, 4);
      wait_rsp(1);

      // Continuous pushes from both clients for 8 grants from a fresh reset.
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      for (int k = 0; k < 8; k++) begin
`ifdef LIFO_ARB_ROUND_ROBIN_EN
         expect_only(k % 2, (k % 2 == 0) ? 8'hA0 : 8'hB1, k >= 4);
`else
         expect_only(0, 8'hA0, k >= 4);
`endif
      end
      hold = 1'b1;
      req_pop = '0;
      req_data = {8'hB1, 8'hA0};
      req_valid = '1;
      wait_rsp(8);
      req_valid = '0;
      hold = 1'b0;
      repeat (6) step();
      check("sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
